// File: rtl/it_ctrl_pkg.sv
// Shared definitions for the Thumb-2 IT block controller.
// Condition codes, ITSTATE geometry and the IT-encoding legality check.
package it_ctrl_pkg;

  localparam int ITSTATE_W = 8;

  localparam int IT_COND_LSB = 4;
  localparam int IT_COND_MSB = 7;
  localparam int IT_MASK_LSB = 0;
  localparam int IT_MASK_MSB = 3;

  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef logic [ITSTATE_W-1:0] itstate_t;

  function automatic logic [2:0] popcnt4(
    input logic [3:0] v
  );
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]}
            + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // An IT byte is UNPREDICTABLE when it opens an
  // empty block, uses NV, or gives AL an else-slot.
  function automatic logic it_bad(
    input itstate_t b
  );
    logic [3:0] fc;
    logic [3:0] mk;
    fc = b[IT_COND_MSB:IT_COND_LSB];
    mk = b[IT_MASK_MSB:IT_MASK_LSB];
    it_bad = (mk == 4'h0)
           || (fc == COND_NV)
           || ((fc == COND_AL) && (popcnt4(mk) != 3'd1));
  endfunction

endpackage

// File: rtl/it_ctrl_if.sv
// Decode-side bundle between pre-decoder and IT controller.
// master: pre-decoder/decode side; slave: it_ctrl.
interface it_ctrl_if;
  import it_ctrl_pkg::*;

  logic       inst_acc;
  logic       it_flag;
  itstate_t   it_status;
  logic       flush;
  logic       epsr_load;
  itstate_t   epsr_it;

  logic [3:0] it_cond;
  logic       in_it_blk;
  logic       last_in_it;
  logic [2:0] it_remain;
  itstate_t   it_state;
  logic       it_err;

  modport master (
    output inst_acc, it_flag, it_status,
    output flush, epsr_load, epsr_it,
    input  it_cond, in_it_blk, last_in_it,
    input  it_remain, it_state, it_err
  );

  modport slave (
    input  inst_acc, it_flag, it_status,
    input  flush, epsr_load, epsr_it,
    output it_cond, in_it_blk, last_in_it,
    output it_remain, it_state, it_err
  );

endinterface

// File: rtl/it_ctrl_adv.sv
// it_adv: combinational ITSTATE advance, remaining count, last flag.
// Ports: cur (itstate in), nxt, remain (0..4), last.
module it_adv
  import it_ctrl_pkg::*;
(
  input  itstate_t   cur,
  output itstate_t   nxt,
  output logic [2:0] remain,
  output logic       last
);

  logic [3:0] mk;
  logic [3:0] lsb;

  assign mk  = cur[IT_MASK_MSB:IT_MASK_LSB];
  // Isolate lowest set mask bit: it marks block end.
  assign lsb = mk & (~mk + 4'd1);

  assign last = (mk == 4'b1000);

  always_comb begin
    nxt = '0;
    if (cur[2:0] != 3'b000) begin
      nxt = {cur[7:5], cur[3:0], 1'b0};
    end
  end

  always_comb begin
    remain = 3'd0;
    unique case (1'b1)
      lsb[0]: remain = 3'd4;
      lsb[1]: remain = 3'd3;
      lsb[2]: remain = 3'd2;
      lsb[3]: remain = 3'd1;
      default: remain = 3'd0;
    endcase
  end

endmodule

// File: rtl/it_ctrl.sv
// it_ctrl: holds ITSTATE, advances it per accepted instruction.
// Ports: clk, rst (sync, high), bus (it_ctrl_if.slave).
module it_ctrl
  import it_ctrl_pkg::*;
#(
  parameter bit CHECK_UNPRED = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  it_ctrl_if.slave  bus
);

  itstate_t   itstate_q;
  itstate_t   itstate_d;
  itstate_t   adv_nxt;
  logic [2:0] adv_rem;
  logic       adv_last;
  logic       in_blk;
  logic       err_d;
  logic       err_q;

  it_adv u_adv (
    .cur    (itstate_q),
    .nxt    (adv_nxt),
    .remain (adv_rem),
    .last   (adv_last)
  );

  assign in_blk = (itstate_q[IT_MASK_MSB:IT_MASK_LSB] != 4'h0);

  always_comb begin
    itstate_d = itstate_q;
    err_d     = 1'b0;
    if (bus.epsr_load) begin
      itstate_d = bus.epsr_it;
    end else if (bus.flush) begin
      itstate_d = '0;
    end else if (bus.inst_acc) begin
      if (in_blk) begin
        // A nested IT executes as a NOP slot.
        itstate_d = adv_nxt;
        err_d     = bus.it_flag;
      end else if (bus.it_flag) begin
        itstate_d = bus.it_status;
        err_d     = it_bad(bus.it_status);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      itstate_q <= '0;
      err_q     <= 1'b0;
    end else begin
      itstate_q <= itstate_d;
      err_q     <= CHECK_UNPRED & err_d;
    end
  end

  assign bus.it_state   = itstate_q;
  assign bus.in_it_blk  = in_blk;
  assign bus.last_in_it = adv_last;
  assign bus.it_remain  = adv_rem;
  assign bus.it_err     = err_q;
  assign bus.it_cond    = in_blk
    ? itstate_q[IT_COND_MSB:IT_COND_LSB]
    : COND_AL;

endmodule

// File: tb/tb_it_ctrl.sv
// Testbench for it_ctrl: directed vector table plus stall sequence.
// Prints one summary line of passed/total checks.
module tb_it_ctrl;
  import it_ctrl_pkg::*;

  logic clk;
  logic rst;

  it_ctrl_if bus ();

  it_ctrl #(.CHECK_UNPRED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       acc;
    logic       itf;
    logic [7:0] sts;
    logic       fl;
    logic       el;
    logic [7:0] eit;
    logic [7:0] x_st;
    logic [3:0] x_cond;
    logic       x_blk;
    logic       x_last;
    logic [2:0] x_rem;
    logic       x_err;
  } vec_t;

  vec_t vecs[$];
  int n_pass;
  int n_tot;

  function automatic vec_t mk(
    input logic r, input logic a, input logic f,
    input logic [7:0] s, input logic fl,
    input logic el, input logic [7:0] e,
    input logic [7:0] xs, input logic [3:0] xc,
    input logic xb, input logic xl,
    input logic [2:0] xr, input logic xe
  );
    vec_t v;
    v.rst = r; v.acc = a; v.itf = f; v.sts = s;
    v.fl = fl; v.el = el; v.eit = e;
    v.x_st = xs; v.x_cond = xc; v.x_blk = xb;
    v.x_last = xl; v.x_rem = xr; v.x_err = xe;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.inst_acc  = v.acc;
    bus.it_flag   = v.itf;
    bus.it_status = v.sts;
    bus.flush     = v.fl;
    bus.epsr_load = v.el;
    bus.epsr_it   = v.eit;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input vec_t v);
    logic ok;
    n_tot++;
    ok = (bus.it_state == v.x_st)
      && (bus.it_cond == v.x_cond)
      && (bus.in_it_blk == v.x_blk)
      && (bus.last_in_it == v.x_last)
      && (bus.it_remain == v.x_rem)
      && (bus.it_err == v.x_err);
    if (ok) n_pass++;
    else
      $display("FAIL %s: got st=%h cond=%h blk=%b last=%b rem=%0d err=%b, want st=%h cond=%h blk=%b last=%b rem=%0d err=%b",
        nm, bus.it_state, bus.it_cond, bus.in_it_blk,
        bus.last_in_it, bus.it_remain, bus.it_err,
        v.x_st, v.x_cond, v.x_blk, v.x_last,
        v.x_rem, v.x_err);
  endtask

  vec_t idle;
  vec_t hold06;

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst           = 1'b1;
    bus.inst_acc  = 1'b0;
    bus.it_flag   = 1'b0;
    bus.it_status = 8'h00;
    bus.flush     = 1'b0;
    bus.epsr_load = 1'b0;
    bus.epsr_it   = 8'h00;

    //        r  a  f  sts   fl el eit    st    c     b  l  rem  e
    // reset / idle
    vecs.push_back(mk(1,0,0,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    // ITTE EQ
    vecs.push_back(mk(0,1,1,8'h06,0,0,8'h00, 8'h06,4'h0,1,0,3'd3,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h0C,4'h0,1,0,3'd2,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h18,4'h1,1,1,3'd1,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    // flush mid-block with accept
    vecs.push_back(mk(0,1,1,8'h06,0,0,8'h00, 8'h06,4'h0,1,0,3'd3,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h0C,4'h0,1,0,3'd2,0));
    vecs.push_back(mk(0,1,0,8'h00,1,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    // epsr_load beats flush
    vecs.push_back(mk(0,1,0,8'h00,1,1,8'h2C, 8'h2C,4'h2,1,0,3'd2,0));
    vecs.push_back(mk(0,0,0,8'h00,1,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    // nested IT
    vecs.push_back(mk(0,1,1,8'h06,0,0,8'h00, 8'h06,4'h0,1,0,3'd3,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h0C,4'h0,1,0,3'd2,0));
    vecs.push_back(mk(0,1,1,8'h48,0,0,8'h00, 8'h18,4'h1,1,1,3'd1,1));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00, 8'h18,4'h1,1,1,3'd1,0));
    // bad encodings
    vecs.push_back(mk(0,0,0,8'h00,1,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    vecs.push_back(mk(0,1,1,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,1));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    vecs.push_back(mk(0,1,1,8'hF8,0,0,8'h00, 8'hF8,4'hF,1,1,3'd1,1));
    vecs.push_back(mk(0,0,0,8'h00,1,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    vecs.push_back(mk(0,1,1,8'hE6,0,0,8'h00, 8'hE6,4'hE,1,0,3'd3,1));
    vecs.push_back(mk(0,0,0,8'h00,1,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    // legal AL single, NE block with cond LSB shift
    vecs.push_back(mk(0,1,1,8'hE8,0,0,8'h00, 8'hE8,4'hE,1,1,3'd1,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    vecs.push_back(mk(0,1,1,8'h16,0,0,8'h00, 8'h16,4'h1,1,0,3'd3,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h0C,4'h0,1,0,3'd2,0));
    // reset mid-block
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h18,4'h1,1,1,3'd1,0));
    vecs.push_back(mk(1,1,0,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    // epsr with empty mask, then four-slot block
    vecs.push_back(mk(0,0,0,8'h00,0,1,8'h70, 8'h70,4'hE,0,0,3'd0,0));
    vecs.push_back(mk(0,0,0,8'h00,1,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));
    vecs.push_back(mk(0,1,1,8'h41,0,0,8'h00, 8'h41,4'h4,1,0,3'd4,0));
    vecs.push_back(mk(0,1,0,8'h00,0,0,8'h00, 8'h42,4'h4,1,0,3'd3,0));
    // epsr_load masks a bad IT and its err
    vecs.push_back(mk(0,1,1,8'h00,0,1,8'h2C, 8'h2C,4'h2,1,0,3'd2,0));
    vecs.push_back(mk(1,0,0,8'h00,0,0,8'h00, 8'h00,4'hE,0,0,3'd0,0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // stall: load ITTE EQ, hold 5 cycles, then advance
    hold06 = mk(0,1,1,8'h06,0,0,8'h00, 8'h06,4'h0,1,0,3'd3,0);
    drive(hold06);
    check("stall_load", hold06);
    idle = mk(0,0,1,8'h48,0,0,8'h00, 8'h06,4'h0,1,0,3'd3,0);
    for (int k = 0; k < 5; k++) begin
      drive(idle);
      check($sformatf("stall%0d", k), idle);
    end
    idle = mk(0,1,0,8'h00,0,0,8'h00, 8'h0C,4'h0,1,0,3'd2,0);
    drive(idle);
    check("stall_resume", idle);

    // nested IT err lasts exactly one cycle
    idle = mk(0,1,1,8'hF0,0,0,8'h00, 8'h18,4'h1,1,1,3'd1,1);
    drive(idle);
    check("nest_pulse", idle);
    idle = mk(0,0,0,8'h00,0,0,8'h00, 8'h18,4'h1,1,1,3'd1,0);
    drive(idle);
    check("nest_clear", idle);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
